// File: rtl/mem_arb_pkg.sv
// Shared types for the unified memory-port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RSP  = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } arb_owner_e;

  localparam int unsigned STARVE_W = 4;

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single memory port between instruction fetch and load/store,
// sequences req/gnt/rvalid, and drops fetch responses made stale by a taken branch.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned STARVE_LIM = 4
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                if_req_i,
  input  logic [ADDR_W-1:0]   if_addr_i,
  output logic [DATA_W-1:0]   if_rdata_o,
  output logic                if_valid_o,
  input  logic                dm_req_i,
  input  logic                dm_we_i,
  input  logic [ADDR_W-1:0]   dm_addr_i,
  input  logic [DATA_W-1:0]   dm_wdata_i,
  input  logic [DATA_W/8-1:0] dm_be_i,
  output logic [DATA_W-1:0]   dm_rdata_o,
  output logic                dm_valid_o,
  input  logic                flush_i,
  output logic                mem_req_o,
  output logic                mem_we_o,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic [DATA_W-1:0]   mem_wdata_o,
  output logic [DATA_W/8-1:0] mem_be_o,
  input  logic                mem_gnt_i,
  input  logic                mem_rvalid_i,
  input  logic [DATA_W-1:0]   mem_rdata_i,
  output logic                stall_fetch_o,
  output logic                stall_mem_o
);

  localparam int unsigned BE_W = DATA_W / 8;
  localparam logic [STARVE_W-1:0] LIM = STARVE_W'(STARVE_LIM);

  arb_state_e            state_q, state_d;
  arb_owner_e            owner_q, owner_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic                  we_q, we_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;
  logic [BE_W-1:0]       be_q, be_d;
  logic [STARVE_W-1:0]   starve_q, starve_d, starve_inc;
  logic                  discard_q, discard_d;
  logic                  fetch_pend, fetch_win, data_win;

  // A flush in IDLE hides the fetch for one cycle; the corrected PC follows.
  assign fetch_pend = if_req_i & ~flush_i;
  assign fetch_win  = fetch_pend & (~dm_req_i | (starve_q >= LIM));
  assign data_win   = dm_req_i & ~fetch_win;
  assign starve_inc = (starve_q >= LIM) ? starve_q : starve_q + STARVE_W'(1);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      owner_q   <= OWN_IF;
      addr_q    <= '0;
      we_q      <= 1'b0;
      wdata_q   <= '0;
      be_q      <= '0;
      starve_q  <= '0;
      discard_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      addr_q    <= addr_d;
      we_q      <= we_d;
      wdata_q   <= wdata_d;
      be_q      <= be_d;
      starve_q  <= starve_d;
      discard_q <= discard_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    addr_d     = addr_q;
    we_d       = we_q;
    wdata_d    = wdata_q;
    be_d       = be_q;
    starve_d   = starve_q;
    discard_d  = discard_q;
    if_valid_o = 1'b0;
    dm_valid_o = 1'b0;
    case (state_q)
      IDLE: begin
        if (fetch_win) begin
          state_d   = REQ;
          owner_d   = OWN_IF;
          addr_d    = if_addr_i;
          we_d      = 1'b0;
          wdata_d   = '0;
          be_d      = '1;
          starve_d  = '0;
          discard_d = 1'b0;
        end else if (data_win) begin
          state_d   = REQ;
          owner_d   = OWN_DM;
          addr_d    = dm_addr_i;
          we_d      = dm_we_i;
          wdata_d   = dm_wdata_i;
          be_d      = dm_be_i;
          starve_d  = if_req_i ? starve_inc : '0;
          discard_d = 1'b0;
        end else if (!if_req_i) begin
          starve_d = '0;
        end
      end
      REQ: begin
        // The request stays on the bus even when its fetch goes stale.
        if (owner_q == OWN_IF && flush_i) discard_d = 1'b1;
        if (mem_gnt_i) begin
          if (owner_q == OWN_DM && we_q) begin
            dm_valid_o = 1'b1;
            state_d    = IDLE;
          end else begin
            state_d = RSP;
          end
        end
      end
      RSP: begin
        if (mem_rvalid_i) begin
          state_d   = IDLE;
          discard_d = 1'b0;
          if (owner_q == OWN_IF) if_valid_o = ~(discard_q | flush_i);
          else                   dm_valid_o = 1'b1;
        end else if (owner_q == OWN_IF && flush_i) begin
          discard_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign mem_req_o     = (state_q == REQ);
  assign mem_we_o      = we_q;
  assign mem_addr_o    = addr_q;
  assign mem_wdata_o   = wdata_q;
  assign mem_be_o      = be_q;
  assign if_rdata_o    = if_valid_o ? mem_rdata_i : '0;
  assign dm_rdata_o    = (dm_valid_o && !we_q) ? mem_rdata_i : '0;
  assign stall_fetch_o = if_req_i & ~if_valid_o;
  assign stall_mem_o   = dm_req_i & ~dm_valid_o;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: transaction-level model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_mem_port_arbiter;

  localparam int unsigned LIM = 2;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        if_req_i, dm_req_i, dm_we_i, flush_i;
  logic [31:0] if_addr_i, dm_addr_i, dm_wdata_i, mem_rdata_i;
  logic [3:0]  dm_be_i;
  logic        mem_gnt_i, mem_rvalid_i;
  logic [31:0] if_rdata_o, dm_rdata_o, mem_addr_o, mem_wdata_o;
  logic        if_valid_o, dm_valid_o, mem_req_o, mem_we_o;
  logic [3:0]  mem_be_o;
  logic        stall_fetch_o, stall_mem_o;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIM(LIM)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_rdata_o(if_rdata_o), .if_valid_o(if_valid_o),
    .dm_req_i(dm_req_i), .dm_we_i(dm_we_i), .dm_addr_i(dm_addr_i), .dm_wdata_i(dm_wdata_i),
    .dm_be_i(dm_be_i), .dm_rdata_o(dm_rdata_o), .dm_valid_o(dm_valid_o),
    .flush_i(flush_i),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o),
    .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
    .stall_fetch_o(stall_fetch_o), .stall_mem_o(stall_mem_o)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit cmp_en = 1'b0;
  int fix_gnt = 0;
  int fix_rv  = 0;

  // Model: the one access in flight, described as a transaction.
  bit          m_busy, m_issued, m_own_if, m_drop, m_we;
  logic [31:0] m_addr, m_wdata;
  logic [3:0]  m_be;
  int          m_starve, m_wait, m_glat, m_rlat;
  bit          last_if_done, last_dm_done, last_flush;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic start_acc(input bit is_fetch);
    m_busy   = 1'b1;
    m_issued = 1'b0;
    m_drop   = 1'b0;
    m_wait   = 0;
    m_glat   = (fix_gnt >= 0) ? fix_gnt : int'($urandom_range(0, 3));
    m_rlat   = (fix_rv  >= 0) ? fix_rv  : int'($urandom_range(0, 3));
    m_own_if = is_fetch;
    if (is_fetch) begin
      m_addr = if_addr_i; m_we = 1'b0;
    end else begin
      m_addr = dm_addr_i; m_we = dm_we_i; m_wdata = dm_wdata_i; m_be = dm_be_i;
    end
  endtask

  // Memory responder: its latencies are picked per access by the model.
  task automatic drive_mem();
    if (!rst_ni) begin
      mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
    end else begin
      mem_gnt_i    = m_busy && !m_issued && (m_wait >= m_glat);
      mem_rvalid_i = m_busy &&  m_issued && (m_wait >= m_rlat);
    end
  endtask

  task automatic model_compare();
    bit e_req, e_ifv, e_dmv;
    e_req = m_busy && !m_issued;
    e_ifv = m_busy && m_issued && m_own_if && mem_rvalid_i && !m_drop && !flush_i;
    e_dmv = m_busy && !m_own_if && ((!m_issued && mem_gnt_i && m_we) || (m_issued && mem_rvalid_i));
    if (cmp_en) begin
      chk("mem_req", 32'(mem_req_o), 32'(e_req));
      chk("if_valid", 32'(if_valid_o), 32'(e_ifv));
      chk("dm_valid", 32'(dm_valid_o), 32'(e_dmv));
      chk("stall_fetch", 32'(stall_fetch_o), 32'(if_req_i && !e_ifv));
      chk("stall_mem", 32'(stall_mem_o), 32'(dm_req_i && !e_dmv));
      if (e_req) begin
        chk("mem_addr", mem_addr_o, m_addr);
        chk("mem_we", 32'(mem_we_o), 32'(m_we));
        if (!m_own_if) chk("mem_be", 32'(mem_be_o), 32'(m_be));
        if (!m_own_if && m_we) chk("mem_wdata", mem_wdata_o, m_wdata);
      end
      if (e_ifv) chk("if_rdata", if_rdata_o, mem_rdata_i);
      if (e_dmv && !m_we) chk("dm_rdata", dm_rdata_o, mem_rdata_i);
    end
    last_if_done = e_ifv;
    last_dm_done = e_dmv;
    last_flush   = flush_i;
  endtask

  task automatic model_update();
    bit fe;
    if (!rst_ni) begin
      m_busy = 0; m_issued = 0; m_drop = 0; m_starve = 0; m_wait = 0;
      m_addr = '0; m_we = 0; m_wdata = '0; m_be = '0;
    end else if (!m_busy) begin
      fe = if_req_i && !flush_i;
      if (dm_req_i && !(fe && m_starve >= int'(LIM))) begin
        start_acc(1'b0);
        m_starve = if_req_i ? ((m_starve < int'(LIM)) ? m_starve + 1 : m_starve) : 0;
      end else if (fe) begin
        start_acc(1'b1);
        m_starve = 0;
      end else if (!if_req_i) begin
        m_starve = 0;
      end
    end else begin
      if (m_own_if && flush_i) m_drop = 1'b1;
      if (!m_issued) begin
        if (mem_gnt_i) begin
          if (m_we) m_busy = 1'b0;
          else begin m_issued = 1'b1; m_wait = 0; end
        end else m_wait++;
      end else begin
        if (mem_rvalid_i) m_busy = 1'b0;
        else m_wait++;
      end
    end
  endtask

  // Inputs are applied at posedge+1; outputs are checked at the negedge.
  task automatic cyc();
    drive_mem();
    #4;
    model_compare();
  endtask

  task automatic adv();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin cyc(); adv(); end
  endtask

  task automatic rand_inputs();
    rst_ni = ($urandom_range(0, 299) != 0);
    if (!rst_ni) begin
      if_req_i = 0; dm_req_i = 0; flush_i = 0;
      return;
    end
    if (last_if_done || !if_req_i) begin
      if_req_i  = ($urandom_range(0, 3) != 0);
      if_addr_i = $urandom & 32'hFFFF_FFFC;
    end else if (last_flush) begin
      if_addr_i = $urandom & 32'hFFFF_FFFC;
    end
    if (last_dm_done || !dm_req_i) begin
      dm_req_i   = ($urandom_range(0, 2) != 0);
      dm_we_i    = 1'($urandom_range(0, 1));
      dm_addr_i  = $urandom & 32'hFFFF_FFFC;
      dm_wdata_i = $urandom;
      dm_be_i    = 4'($urandom);
    end
    flush_i     = ($urandom_range(0, 7) == 0);
    mem_rdata_i = $urandom;
  endtask

  int exp_d, exp_f;

  initial begin
    rst_ni = 0; if_req_i = 0; dm_req_i = 0; dm_we_i = 0; flush_i = 0;
    if_addr_i = 0; dm_addr_i = 0; dm_wdata_i = 0; dm_be_i = 0;
    mem_gnt_i = 0; mem_rvalid_i = 0; mem_rdata_i = 0;
    m_busy = 0; m_issued = 0; m_drop = 0; m_starve = 0; m_wait = 0;
    m_glat = 0; m_rlat = 0; m_own_if = 0; m_we = 0; m_addr = 0; m_wdata = 0; m_be = 0;
    @(posedge clk); #1;
    cyc(); adv();
    cmp_en = 1'b1;
    step(1);
    rst_ni = 1;

    // Reset state
    cyc();
    chk("rst mem_req", 32'(mem_req_o), 0);
    chk("rst mem_addr", mem_addr_o, 0);
    chk("rst mem_be", 32'(mem_be_o), 0);
    chk("rst if_rdata", if_rdata_o, 0);
    chk("rst dm_valid", 32'(dm_valid_o), 0);
    adv();

    // Lone fetch
    if_req_i = 1; if_addr_i = 32'h100; mem_rdata_i = 32'hDEAD_BEEF;
    cyc(); chk("lone N mem_req", 32'(mem_req_o), 0); chk("lone N stall", 32'(stall_fetch_o), 1); adv();
    cyc(); chk("lone N+1 mem_req", 32'(mem_req_o), 1); chk("lone N+1 addr", mem_addr_o, 32'h100);
    chk("lone N+1 stall", 32'(stall_fetch_o), 1); adv();
    cyc(); chk("lone N+2 valid", 32'(if_valid_o), 1); chk("lone N+2 rdata", if_rdata_o, 32'hDEAD_BEEF);
    chk("lone N+2 stall", 32'(stall_fetch_o), 0); adv();
    if_req_i = 0;
    cyc(); chk("lone N+3 mem_req", 32'(mem_req_o), 0); adv();

    // Simultaneous fetch and load: load first
    if_req_i = 1; if_addr_i = 32'h104;
    dm_req_i = 1; dm_we_i = 0; dm_addr_i = 32'h2000; dm_be_i = 4'hF; dm_wdata_i = 32'h0;
    step(1);
    cyc(); chk("sim load addr", mem_addr_o, 32'h2000); chk("sim load we", 32'(mem_we_o), 0); adv();
    mem_rdata_i = 32'h1111_2222;
    cyc(); chk("sim dm_valid", 32'(dm_valid_o), 1); chk("sim dm_rdata", dm_rdata_o, 32'h1111_2222);
    chk("sim if_valid", 32'(if_valid_o), 0); adv();
    dm_req_i = 0;
    cyc(); chk("sim idle", 32'(mem_req_o), 0); adv();
    cyc(); chk("sim fetch addr", mem_addr_o, 32'h104); adv();
    mem_rdata_i = 32'h3333_4444;
    cyc(); chk("sim if_valid2", 32'(if_valid_o), 1); adv();
    if_req_i = 0;

    // Store with delayed grant
    fix_gnt = 3;
    dm_req_i = 1; dm_we_i = 1; dm_addr_i = 32'h2004; dm_wdata_i = 32'hCAFE_F00D; dm_be_i = 4'b0011;
    step(1);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("st addr", mem_addr_o, 32'h2004); chk("st be", 32'(mem_be_o), 32'h3);
      chk("st wdata", mem_wdata_o, 32'hCAFE_F00D); chk("st we", 32'(mem_we_o), 1);
      chk("st early valid", 32'(dm_valid_o), 0);
      adv();
    end
    cyc(); chk("st gnt req", 32'(mem_req_o), 1); chk("st gnt valid", 32'(dm_valid_o), 1); adv();
    fix_gnt = 0;
    dm_req_i = 0; if_req_i = 1; if_addr_i = 32'h108;
    cyc(); chk("st after idle", 32'(mem_req_o), 0); adv();
    cyc(); chk("st next fetch", mem_addr_o, 32'h108); adv();
    step(1);

    // Starvation guard (limit 2): D D F D D F
    if_addr_i = 32'h200; dm_req_i = 1; dm_we_i = 0; dm_addr_i = 32'h3000; dm_be_i = 4'hF;
    exp_d = 0; exp_f = 0;
    for (int k = 0; k < 6; k++) begin
      step(1);
      cyc();
      if (k % 3 == 2) begin chk("starve fetch", mem_addr_o, 32'h200 + 32'(exp_f * 4)); exp_f++; end
      else            begin chk("starve data", mem_addr_o, 32'h3000 + 32'(exp_d * 4)); exp_d++; end
      adv();
      cyc(); adv();
      if (last_dm_done) dm_addr_i = dm_addr_i + 32'h4;
      if (last_if_done) if_addr_i = if_addr_i + 32'h4;
    end
    dm_req_i = 0;
    chk("starve model count", 32'(m_starve), 0);

    // Flush in RSP before rvalid
    fix_rv = 1; if_addr_i = 32'h300;
    step(2);
    flush_i = 1;
    cyc(); chk("flA rsp valid", 32'(if_valid_o), 0); adv();
    flush_i = 0; if_addr_i = 32'h400;
    cyc(); chk("flA rvalid drop", 32'(if_valid_o), 0); adv();
    step(1);
    cyc(); chk("flA refetch addr", mem_addr_o, 32'h400); adv();
    step(1);
    mem_rdata_i = 32'h0BAD_F00D;
    cyc(); chk("flA refetch valid", 32'(if_valid_o), 1); chk("flA rdata", if_rdata_o, 32'h0BAD_F00D); adv();

    // Flush coincident with rvalid
    fix_rv = 0; if_addr_i = 32'h500;
    step(2);
    flush_i = 1;
    cyc(); chk("flB drop", 32'(if_valid_o), 0); adv();
    flush_i = 0; if_addr_i = 32'h600;
    step(1);
    cyc(); chk("flB refetch addr", mem_addr_o, 32'h600); adv();
    cyc(); chk("flB refetch valid", 32'(if_valid_o), 1); adv();
    if_req_i = 0;

    // Reset mid-access
    fix_gnt = 3; if_req_i = 1; if_addr_i = 32'h700;
    step(1);
    cyc(); chk("rstm in req", 32'(mem_req_o), 1); adv();
    rst_ni = 0; if_req_i = 0;
    step(1);
    rst_ni = 1;
    cyc();
    chk("rstm mem_req", 32'(mem_req_o), 0); chk("rstm addr", mem_addr_o, 0);
    chk("rstm be", 32'(mem_be_o), 0); chk("rstm we", 32'(mem_we_o), 0);
    chk("rstm wdata", mem_wdata_o, 0); chk("rstm stall_fetch", 32'(stall_fetch_o), 0);
    adv();
    fix_gnt = 0;
    dm_req_i = 1; dm_we_i = 0; dm_addr_i = 32'h800; dm_be_i = 4'hF;
    step(1);
    cyc(); chk("rstm idle then load", mem_addr_o, 32'h800); adv();
    step(1);
    dm_req_i = 0;
    step(1);

    // Randomized traffic
    fix_gnt = -1; fix_rv = -1;
    for (int c = 0; c < 3000; c++) begin
      rand_inputs();
      cyc(); adv();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
